// File: rtl/wave_mixer.sv
// Multi-cycle averaging mixer: sums playing channels serially, divides by the active count.
// Optional WAVE_MIXER_ROUND_EN turns the floor division into round-half-up.
module wave_mixer #(
   parameter int NUM_CH   = 16,
   parameter int SAMPLE_W = 6,
   localparam int CNT_W   = $clog2(NUM_CH + 1),
   localparam int SUM_W   = SAMPLE_W + CNT_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          playing,
   input  logic [NUM_CH*SAMPLE_W-1:0] waves,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SAMPLE_W-1:0]        mix,
   output logic [CNT_W-1:0]           active_count
);

   localparam int BIT_W = $clog2(SUM_W + 1);

   typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} state_t;

   state_t                      r_state;
   state_t                      w_nextState;

   logic [NUM_CH-1:0]           r_playing;
   logic [NUM_CH*SAMPLE_W-1:0]  r_waves;
   logic [SUM_W-1:0]            r_acc;
   logic [SUM_W:0]              r_rem;
   logic [SAMPLE_W-1:0]         r_quot;
   logic [CNT_W-1:0]            r_count;
   logic [CNT_W-1:0]            r_idx;
   logic [BIT_W-1:0]            r_bitCnt;
   logic [SAMPLE_W-1:0]         r_mix;
   logic [CNT_W-1:0]            r_activeCount;

   logic                        w_accept;
   logic [SAMPLE_W-1:0]         w_sample;
   logic                        w_chActive;
   logic [SUM_W-1:0]            w_accSum;
   logic [CNT_W-1:0]            w_countSum;
   logic                        w_lastCh;
   logic [SUM_W-1:0]            w_dividend;
   logic [SUM_W:0]              w_shifted;
   logic [SUM_W+1:0]            w_trial;
   logic                        w_qBit;
   logic [SUM_W:0]              w_remNext;
   logic [SAMPLE_W-1:0]         w_quotNext;
   logic                        w_lastBit;

   assign in_ready     = (r_state == IDLE) && !reset;
   assign out_valid    = (r_state == DONE);
   assign mix          = r_mix;
   assign active_count = r_activeCount;
   assign w_accept     = in_valid && in_ready;

   // The captured frame shifts down each SUM cycle, so channel idx is always in the low slot.
   assign w_sample   = r_waves[SAMPLE_W-1:0];
   assign w_chActive = r_playing[0];
   assign w_accSum   = w_chActive ? r_acc + {{CNT_W{1'b0}}, w_sample} : r_acc;
   assign w_countSum = w_chActive ? r_count + CNT_W'(1) : r_count;
   assign w_lastCh   = (r_idx == CNT_W'(NUM_CH - 1));

`ifdef WAVE_MIXER_ROUND_EN
   assign w_dividend = w_accSum + SUM_W'(w_countSum >> 1);
`else
   assign w_dividend = w_accSum;
`endif

   // Remainder stays below count, so its top bit is always zero and shifting it out is lossless.
   assign w_shifted  = (SUM_W + 1)'({r_rem, r_acc[SUM_W-1]});
   assign w_trial    = {1'b0, w_shifted} - {{(SUM_W + 2 - CNT_W){1'b0}}, r_count};
   assign w_qBit     = ~w_trial[SUM_W+1];
   assign w_remNext  = w_qBit ? w_trial[SUM_W:0] : w_shifted;
   assign w_quotNext = (r_quot << 1) | SAMPLE_W'(w_qBit);
   assign w_lastBit  = (r_bitCnt == BIT_W'(SUM_W - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: if (w_accept) w_nextState = SUM;
         SUM: begin
            if (w_lastCh) begin
               w_nextState = (w_countSum == '0) ? DONE : DIV;
            end
         end
         DIV:  if (w_lastBit) w_nextState = DONE;
         DONE: if (out_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_playing     <= '0;
         r_waves       <= '0;
         r_acc         <= '0;
         r_rem         <= '0;
         r_quot        <= '0;
         r_count       <= '0;
         r_idx         <= '0;
         r_bitCnt      <= '0;
         r_mix         <= '0;
         r_activeCount <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_playing <= playing;
                  r_waves   <= waves;
                  r_acc     <= '0;
                  r_rem     <= '0;
                  r_quot    <= '0;
                  r_count   <= '0;
                  r_idx     <= '0;
                  r_bitCnt  <= '0;
               end
            end
            SUM: begin
               r_playing <= r_playing >> 1;
               r_waves   <= r_waves >> SAMPLE_W;
               r_idx     <= r_idx + CNT_W'(1);
               r_count   <= w_countSum;
               if (w_lastCh) begin
                  r_acc         <= w_dividend;
                  r_activeCount <= w_countSum;
                  if (w_countSum == '0) begin
                     r_mix <= '0;
                  end
               end else begin
                  r_acc <= w_accSum;
               end
            end
            DIV: begin
               r_acc    <= r_acc << 1;
               r_rem    <= w_remNext;
               r_quot   <= w_quotNext;
               r_bitCnt <= r_bitCnt + BIT_W'(1);
               if (w_lastBit) begin
                  r_mix <= w_quotNext;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wave_mixer.sv
// Self-checking bench for wave_mixer: table vectors, random frames, backpressure, reset abort
// and a NUM_CH=4/SAMPLE_W=8 instance. Honours WAVE_MIXER_ROUND_EN in its expectations.
module tb_wave_mixer;

   localparam int NUM_CH   = 16;
   localparam int SAMPLE_W = 6;
   localparam int CNT_W    = 5;
   localparam int SUM_W    = 11;
   localparam int WW       = NUM_CH * SAMPLE_W;

   logic               clk;
   logic               reset;
   logic [NUM_CH-1:0]  playing;
   logic [WW-1:0]      waves;
   logic               in_valid;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic [SAMPLE_W-1:0] mix;
   logic [CNT_W-1:0]   active_count;

   logic [3:0]         playing4;
   logic [31:0]        waves4;
   logic               inValid4;
   logic               inReady4;
   logic               outValid4;
   logic               outReady4;
   logic [7:0]         mix4;
   logic [2:0]         activeCount4;

   wave_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) dut (
      .clk(clk), .reset(reset), .playing(playing), .waves(waves),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .mix(mix), .active_count(active_count)
   );

   wave_mixer #(.NUM_CH(4), .SAMPLE_W(8)) dut4 (
      .clk(clk), .reset(reset), .playing(playing4), .waves(waves4),
      .in_valid(inValid4), .in_ready(inReady4), .out_valid(outValid4),
      .out_ready(outReady4), .mix(mix4), .active_count(activeCount4)
   );

   typedef struct {
      logic [NUM_CH-1:0] playing;
      logic [WW-1:0]     waves;
      int                expTrunc;
      int                expRound;
      int                expCnt;
   } vec_t;

   typedef struct {
      int mixV;
      int cntV;
      int lat;
   } exp_t;

   exp_t sbQ[$];
   vec_t vecs[7];
   int   nVec = 0;
   int   nMis = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [WW-1:0] setCh(input logic [WW-1:0] w, input int ch, input int val);
      logic [WW-1:0] r;
      r = w;
      r[ch*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(val);
      return r;
   endfunction

   function automatic int pickExp(input vec_t v);
`ifdef WAVE_MIXER_ROUND_EN
      return v.expRound;
`else
      return v.expTrunc;
`endif
   endfunction

   // Reference average straight from the arithmetic definition.
   task automatic modelFrame(input logic [NUM_CH-1:0] p, input logic [WW-1:0] w,
                             output int eMix, output int eCnt);
      int sum;
      sum  = 0;
      eCnt = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (p[i]) begin
            sum += int'(w[i*SAMPLE_W +: SAMPLE_W]);
            eCnt++;
         end
      end
      if (eCnt == 0) begin
         eMix = 0;
      end else begin
`ifdef WAVE_MIXER_ROUND_EN
         sum += eCnt / 2;
`endif
         eMix = sum / eCnt;
      end
   endtask

   task automatic applyStimulus(input logic [NUM_CH-1:0] p, input logic [WW-1:0] w,
                                input int eMix, input int eCnt);
      exp_t e;
      expectEq("in_ready_before_accept", {31'b0, in_ready}, 1);
      playing  = p;
      waves    = w;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      playing  = NUM_CH'($urandom);
      waves    = {$urandom, $urandom, $urandom};
      e.mixV = eMix;
      e.cntV = eCnt;
      e.lat  = (eCnt == 0) ? NUM_CH : NUM_CH + SUM_W;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput(input int holdCycles, input bit pokeInValid);
      exp_t e;
      int   cyc;
      logic [SAMPLE_W-1:0] heldMix;
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!out_valid) begin
         nVec++;
         nMis++;
         $display("[TB] FAIL out_valid_timeout: got no out_valid after %0d cycles, expected one", cyc);
         if (sbQ.size() > 0) void'(sbQ.pop_front());
         return;
      end
      if (sbQ.size() == 0) begin
         nVec++;
         nMis++;
         $display("[TB] FAIL unexpected_output: got out_valid, expected none queued");
         return;
      end
      e = sbQ.pop_front();
      expectEq("latency", cyc, e.lat);
      expectEq("mix", {26'b0, mix}, e.mixV);
      expectEq("active_count", {27'b0, active_count}, e.cntV);
      heldMix = mix;
      for (int k = 0; k < holdCycles; k++) begin
         if (pokeInValid && k == 3) begin
            playing  = '1;
            waves    = '1;
            in_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         expectEq("hold_out_valid", {31'b0, out_valid}, 1);
         expectEq("hold_mix", {26'b0, mix}, {26'b0, heldMix});
         expectEq("hold_in_ready", {31'b0, in_ready}, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      expectEq("out_valid_drop", {31'b0, out_valid}, 0);
      expectEq("in_ready_after_consume", {31'b0, in_ready}, 1);
   endtask

   task automatic expectQuiet(input string name, input int cycles);
      bit saw;
      saw = 1'b0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) saw = 1'b1;
      end
      expectEq(name, {31'b0, saw}, 0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int eMix;
      int eCnt;
      int cyc;
      logic [NUM_CH-1:0] rp;
      logic [WW-1:0]     rw;

      // Hand-computed vectors: sums, floors and round-half-up results worked out by hand.
      vecs[0].playing = 16'hFFFF; vecs[0].waves = '1;
      vecs[0].expTrunc = 63; vecs[0].expRound = 63; vecs[0].expCnt = 16;

      vecs[1].playing = 16'h0005; vecs[1].waves = '0;
      vecs[1].waves = setCh(vecs[1].waves, 0, 10);
      vecs[1].waves = setCh(vecs[1].waves, 1, 63);
      vecs[1].waves = setCh(vecs[1].waves, 2, 21);
      vecs[1].expTrunc = 15; vecs[1].expRound = 16; vecs[1].expCnt = 2;

      vecs[2].playing = 16'h0000; vecs[2].waves = '1;
      vecs[2].expTrunc = 0; vecs[2].expRound = 0; vecs[2].expCnt = 0;

      vecs[3].playing = 16'h8000; vecs[3].waves = '0;
      for (int i = 0; i < NUM_CH; i++) vecs[3].waves = setCh(vecs[3].waves, i, 5);
      vecs[3].waves = setCh(vecs[3].waves, 15, 37);
      vecs[3].expTrunc = 37; vecs[3].expRound = 37; vecs[3].expCnt = 1;

      vecs[4].playing = 16'h00FF; vecs[4].waves = '1;
      for (int i = 0; i < 8; i++) vecs[4].waves = setCh(vecs[4].waves, i, i + 1);
      vecs[4].expTrunc = 4; vecs[4].expRound = 5; vecs[4].expCnt = 8;

      vecs[5].playing = 16'hAAAA; vecs[5].waves = '0;
      for (int i = 0; i < NUM_CH; i++) vecs[5].waves = setCh(vecs[5].waves, i, i * 4);
      vecs[5].expTrunc = 32; vecs[5].expRound = 32; vecs[5].expCnt = 8;

      vecs[6].playing = 16'h0007; vecs[6].waves = '0;
      vecs[6].waves = setCh(vecs[6].waves, 0, 1);
      vecs[6].waves = setCh(vecs[6].waves, 1, 1);
      vecs[6].expTrunc = 0; vecs[6].expRound = 1; vecs[6].expCnt = 3;

      reset     = 1'b1;
      playing   = '0;
      waves     = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      playing4  = '0;
      waves4    = '0;
      inValid4  = 1'b0;
      outReady4 = 1'b0;

      repeat (3) begin
         @(posedge clk);
         #1;
         expectEq("reset_out_valid", {31'b0, out_valid}, 0);
         expectEq("reset_mix", {26'b0, mix}, 0);
         expectEq("reset_in_ready", {31'b0, in_ready}, 0);
      end
      expectEq("reset_active_count", {27'b0, active_count}, 0);
      expectEq("reset_out_valid4", {31'b0, outValid4}, 0);
      reset = 1'b0;
      #1;
      expectEq("in_ready_after_reset", {31'b0, in_ready}, 1);

      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].playing, vecs[v].waves, pickExp(vecs[v]), vecs[v].expCnt);
         checkOutput(0, 1'b0);
      end

      // Backpressure with a stray in_valid pulse while DONE is held.
      applyStimulus(vecs[1].playing, vecs[1].waves, pickExp(vecs[1]), vecs[1].expCnt);
      checkOutput(10, 1'b1);
      expectQuiet("stray_in_valid_ignored", NUM_CH + SUM_W + 4);

      out_ready = 1'b1;
      applyStimulus(vecs[3].playing, vecs[3].waves, pickExp(vecs[3]), vecs[3].expCnt);
      checkOutput(0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         rp = NUM_CH'($urandom);
         if (r == 0) rp = '0;
         rw = {$urandom, $urandom, $urandom};
         modelFrame(rp, rw, eMix, eCnt);
         applyStimulus(rp, rw, eMix, eCnt);
         checkOutput(r % 3, 1'b0);
      end

      // Abort a frame in the middle of the divide.
      playing  = vecs[0].playing;
      waves    = vecs[0].waves;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (19) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      #1;
      expectEq("in_ready_during_midreset", {31'b0, in_ready}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      expectEq("out_valid_after_midreset", {31'b0, out_valid}, 0);
      expectEq("in_ready_after_midreset", {31'b0, in_ready}, 1);
      expectQuiet("aborted_frame_silent", NUM_CH + SUM_W + 4);
      applyStimulus(vecs[4].playing, vecs[4].waves, pickExp(vecs[4]), vecs[4].expCnt);
      checkOutput(0, 1'b0);

      // Narrow, wide-sample instance: 255+255+255+1 over 4 channels.
      playing4 = 4'hF;
      waves4   = {8'd1, 8'd255, 8'd255, 8'd255};
      inValid4 = 1'b1;
      @(posedge clk);
      #1;
      inValid4 = 1'b0;
      cyc = 0;
      while (!outValid4 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      expectEq("p4_latency", cyc, 15);
`ifdef WAVE_MIXER_ROUND_EN
      expectEq("p4_mix", {24'b0, mix4}, 192);
`else
      expectEq("p4_mix", {24'b0, mix4}, 191);
`endif
      expectEq("p4_active_count", {29'b0, activeCount4}, 4);
      outReady4 = 1'b1;
      @(posedge clk);
      #1;
      outReady4 = 1'b0;
      expectEq("p4_out_valid_drop", {31'b0, outValid4}, 0);
      expectEq("p4_in_ready_after", {31'b0, inReady4}, 1);

      expectEq("scoreboard_empty", sbQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule

// File: doc/wave_mixer.md
# wave_mixer

Sequential, parametrised mixer of per-key sample streams. It sums only the channels flagged as playing, divides by the active-channel count with a bit-serial restoring divider, and presents the averaged sample on a valid/ready output. It sits between the per-key wave generators and the audio DAC serializer. It replaces the single-cycle adder/divider pair with a multi-cycle, handshaked datapath that scales in channel count and sample width.

## Interface

Parameters:
- NUM_CH, 16: number of input channels (≥1)
- SAMPLE_W, 6: width of each unsigned input sample and of the output sample
- Derived, not overridable:
  - CNT_W = $clog2(NUM_CH+1)
  - SUM_W = SAMPLE_W + CNT_W

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk, input, 1: rising-edge clock for all state
  - reset, input, 1: synchronous, active-high reset
- Input side:
  - playing, input, NUM_CH: bit i set = channel i active
  - waves, input, NUM_CH*SAMPLE_W: channel i at [i*SAMPLE_W +: SAMPLE_W], unsigned
  - in_valid, input, 1: playing/waves valid
  - in_ready, output, 1: block can accept a frame
- Output side:
  - out_valid, output, 1: mix/active_count valid
  - out_ready, input, 1: consumer accepts the output
  - mix, output, SAMPLE_W: averaged sample
  - active_count, output, CNT_W: number of active channels in this frame

## Operation

- FSM states: IDLE, SUM, DIV, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid && in_ready, register playing and waves, clear the accumulator, the channel index and the count, then go to SUM.
- SUM (NUM_CH cycles)
  - Each cycle examines channel idx, ascending from 0.
  - If playing[idx] is set, acc += sample[idx] and count += 1. Inactive channels contribute nothing, whatever their sample value.
  - After idx = NUM_CH-1:
    - count == 0: mix = 0, go to DONE (DIV is skipped).
    - otherwise go to DIV.
- DIV (SUM_W cycles)
  - Restoring division of acc (SUM_W bits) by count, one quotient bit per cycle, MSB first.
  - The remainder is SUM_W+1 bits wide to hold the trial subtraction.
  - After the final bit, mix = quotient[SAMPLE_W-1:0], go to DONE.
  - The quotient never exceeds 2^SAMPLE_W-1, so no saturation is needed.
- DONE
  - out_valid = 1; mix and active_count are held stable.
  - On out_ready, go to IDLE.
- in_ready is high only in IDLE and is forced to 0 while reset is high.
- No new frame is accepted until the output has been consumed (single-frame buffering).
- Truncating division unless the rounding feature is compiled in (see Configuration).

## Timing

- Reset (synchronous): state = IDLE, out_valid = 0, mix = 0, active_count = 0, and acc, count, idx, quotient and remainder are cleared.
- Reset has priority over every other event, including mid-SUM, mid-DIV and in DONE. The frame is discarded and no out_valid pulse results.
- Latency, with the accept edge as cycle 0:
  - out_valid rises after edge NUM_CH + SUM_W when count > 0 (default 16+11 = 27).
  - out_valid rises after edge NUM_CH when count == 0 (default 16).
- Output consumption:
  - out_valid falls on the edge where out_valid && out_ready.
  - in_ready is high in the following cycle.
  - Minimum frame period is therefore latency + 2 cycles.
- out_ready held high in advance: DONE lasts exactly one cycle.
- in_valid asserted outside IDLE is ignored and not queued.
- playing and waves changing after the accept edge have no effect on the frame in flight.

## Configuration

- Macro: WAVE_MIXER_ROUND_EN.
- Defined:
  - At SUM→DIV, acc is loaded as acc + (count >> 1), giving round-half-up to nearest.
  - The result is still bounded by 2^SAMPLE_W-1, and latency is unchanged.
- Undefined: truncating division (floor).

## Test plan

- Reset then idle: hold reset 3 cycles → out_valid = 0, mix = 0, in_ready = 0 during reset and 1 on the first cycle after.
- All 16 channels active, every sample 63 → out_valid at cycle 27, mix = 63, active_count = 16.
- Mixed channels and truncation:
  - playing = 0x0005, ch0 = 10, ch2 = 21, ch1 = 63 (inactive) → mix = 15, active_count = 2.
  - With WAVE_MIXER_ROUND_EN defined, the same frame gives mix = 16.
- Silent frame:
  - playing = 0, samples nonzero → out_valid at cycle 16, mix = 0, active_count = 0.
  - There is no divide-by-zero.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid → mix stable, in_ready = 0, and an in_valid pulse is ignored.
  - Then out_ready = 1 → in_ready high the next cycle.
- Reset mid-DIV: assert reset at cycle 20 of a frame → out_valid stays 0, the block is in IDLE afterwards, and a subsequent frame produces the correct result.
- Parameter sweep: NUM_CH = 4, SAMPLE_W = 8, playing = 0xF, samples 255/255/255/1 → mix = 191, latency 4+11 = 15.
